// File: rtl/data_mover_pkg.sv
// Shared types and helpers for the data mover scheduler: FSM encoding,
// descriptor layout and burst legality.
package data_mover_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_REJECT = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int MAX_BURST = 4096;
    localparam int DESC_W    = 205;

    typedef struct packed {
        logic [63:0] src;
        logic [63:0] dst;
        logic [63:0] bytes;
        logic [12:0] burst;
    } desc_t;

    // A burst must be a power of two between one data beat and MAX_BURST.
    function automatic logic burst_legal(input logic [12:0] burst, input int dw);
        logic [31:0] b;
        b = {19'd0, burst};
        return (b != 32'd0) && ((b & (b - 32'd1)) == 32'd0) &&
               (b >= 32'(dw / 8)) && (b <= 32'(MAX_BURST));
    endfunction

endpackage

// File: rtl/data_mover_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a held
// pointer; the pointer is reloaded from ptr_in when a grant is taken.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] ptr_in,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    logic [IW-1:0] ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ptr <= '0;
        else if (advance)
            ptr <= ptr_in;
    end

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        index = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                index      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/data_mover_sched.sv
// Round-robin scheduler sharing one data_mover between NREQ requesters:
// accepts a descriptor, validates it, launches the mover and reports done/err.
module data_mover_sched
    import data_mover_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 512
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               sched_enable,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*64-1:0] req_src,
    input  logic [NREQ*64-1:0] req_dst,
    input  logic [NREQ*64-1:0] req_bytes,
    input  logic [NREQ*13-1:0] req_burst,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic [31:0]        moves_done,
    output logic [31:0]        moves_err,
    output logic [63:0]        dm_src_address,
    output logic [63:0]        dm_dst_address,
    output logic [63:0]        dm_byte_count,
    output logic [12:0]        dm_burst_size,
    output logic               dm_start,
    input  logic               dm_idle
);

    localparam int AW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    state_t          state_next;
    logic [NREQ-1:0] arb_grant;
    logic [AW-1:0]   arb_index;
    logic [AW-1:0]   ptr_next;
    logic [NREQ-1:0] grant_onehot;
    logic            handshake;
    logic            first_wait;
    logic            desc_legal;
    logic [3:0]      burst_log2;
    desc_t           sel_desc;

    assign handshake    = (state == S_IDLE) && sched_enable && (req_valid != '0);
    assign ptr_next     = (arb_index == AW'(NREQ - 1)) ? '0 : arb_index + AW'(1);
    assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;

    rr_arbiter #(.N(NREQ), .IW(AW)) u_arb (
        .clk    (clk),
        .resetn (resetn),
        .req    (req_valid),
        .advance(handshake),
        .ptr_in (ptr_next),
        .grant  (arb_grant),
        .index  (arb_index)
    );

    always_comb begin
        sel_desc.src   = req_src[int'(arb_index) * 64 +: 64];
        sel_desc.dst   = req_dst[int'(arb_index) * 64 +: 64];
        sel_desc.bytes = req_bytes[int'(arb_index) * 64 +: 64];
        sel_desc.burst = req_burst[int'(arb_index) * 13 +: 13];
    end

    // Burst is a power of two when legal, so division reduces to a shift.
    always_comb begin
        burst_log2 = '0;
        for (int i = 0; i < 13; i++)
            if (dm_burst_size[i]) burst_log2 = 4'(i);
        desc_legal = burst_legal(dm_burst_size, DW) &&
                     (dm_byte_count != 64'd0) &&
                     ((dm_byte_count[12:0] & (dm_burst_size - 13'd1)) == 13'd0) &&
                     ((dm_byte_count >> burst_log2) <= 64'h0000_0000_FFFF_FFFF);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (handshake) state_next = S_CHECK;
            S_CHECK:  state_next = desc_legal ? S_START : S_REJECT;
            S_REJECT: state_next = S_IDLE;
            S_START:  state_next = S_WAIT;
            S_WAIT:   if (!first_wait && dm_idle) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        done      = '0;
        err       = '0;
        dm_start  = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:   if (sched_enable) req_ready = arb_grant;
            S_REJECT: err = grant_onehot;
            S_START:  dm_start = 1'b1;
            S_DONE:   done = grant_onehot;
            default:  ;
        endcase
    end

    // first_wait masks dm_idle for the cycle the mover needs to register start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            first_wait     <= 1'b0;
            grant_id       <= '0;
            dm_src_address <= '0;
            dm_dst_address <= '0;
            dm_byte_count  <= '0;
            dm_burst_size  <= '0;
            moves_done     <= '0;
            moves_err      <= '0;
        end else begin
            first_wait <= (state == S_START);
            if (handshake) begin
                grant_id       <= 3'(arb_index);
                dm_src_address <= sel_desc.src;
                dm_dst_address <= sel_desc.dst;
                dm_byte_count  <= sel_desc.bytes;
                dm_burst_size  <= sel_desc.burst;
            end
            if (state == S_DONE)
                moves_done <= moves_done + 32'd1;
            if (state == S_REJECT)
                moves_err <= moves_err + 32'd1;
        end
    end

endmodule

// File: tb/tb_data_mover_sched.sv
// Directed bench for data_mover_sched with a behavioural mover that holds
// dm_idle low for a programmable number of cycles after each dm_start.
module tb_data_mover_sched;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              sched_enable;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*64-1:0] req_src;
    logic [NREQ*64-1:0] req_dst;
    logic [NREQ*64-1:0] req_bytes;
    logic [NREQ*13-1:0] req_burst;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic              busy;
    logic [2:0]        grant_id;
    logic [31:0]       moves_done;
    logic [31:0]       moves_err;
    logic [63:0]       dm_src_address;
    logic [63:0]       dm_dst_address;
    logic [63:0]       dm_byte_count;
    logic [12:0]       dm_burst_size;
    logic              dm_start;
    logic              dm_idle;

    int n_checks = 0;
    int n_fail   = 0;
    int mover_cycles = 5;

    logic [63:0] bad_bytes [5] = '{64'd0, 64'd100, 64'd96, 64'd64, 64'h40_0000_0000};
    logic [12:0] bad_burst [5] = '{13'd4096, 13'd64, 13'd48, 13'd32, 13'd64};

    data_mover_sched #(.NREQ(NREQ), .DW(512)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .sched_enable  (sched_enable),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_src       (req_src),
        .req_dst       (req_dst),
        .req_bytes     (req_bytes),
        .req_burst     (req_burst),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .grant_id      (grant_id),
        .moves_done    (moves_done),
        .moves_err     (moves_err),
        .dm_src_address(dm_src_address),
        .dm_dst_address(dm_dst_address),
        .dm_byte_count (dm_byte_count),
        .dm_burst_size (dm_burst_size),
        .dm_start      (dm_start),
        .dm_idle       (dm_idle)
    );

    always #5 clk = ~clk;

    // Behavioural mover: busy for mover_cycles cycles after each start.
    initial begin
        dm_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (resetn && dm_start) begin
                dm_idle = 1'b0;
                repeat (mover_cycles) @(negedge clk);
                dm_idle = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int i, input logic [63:0] src, input logic [63:0] dst,
                                 input logic [63:0] bytes, input logic [12:0] burst);
        req_src[i*64 +: 64]   = src;
        req_dst[i*64 +: 64]   = dst;
        req_bytes[i*64 +: 64] = bytes;
        req_burst[i*13 +: 13] = burst;
    endtask

    task automatic applyReset();
        resetn       = 1'b0;
        req_valid    = '0;
        sched_enable = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Wait for the grant to idx, then follow the move to its done or err pulse.
    task automatic serve(input int idx, input bit legal, input logic [NREQ-1:0] drop,
                         input string tag);
        int n;
        int starts;
        n = 0;
        #1;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_ready"}, req_ready, oh(idx));
        if (req_ready == '0) return;
        @(negedge clk);
        req_valid = req_valid & ~drop;
        checkOutput({tag, "_grant"}, grant_id, idx);
        starts = 0;
        n = 0;
        while (done == '0 && err == '0 && n < 400) begin
            if (dm_start) starts++;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done"}, done, legal ? oh(idx) : '0);
        checkOutput({tag, "_err"}, err, legal ? '0 : oh(idx));
        checkOutput({tag, "_starts"}, starts, legal ? 1 : 0);
    endtask

    initial begin
        int n;
        int dcount;
        resetn       = 1'b0;
        sched_enable = 1'b0;
        req_valid    = '0;
        req_src      = '0;
        req_dst      = '0;
        req_bytes    = '0;
        req_burst    = '0;

        @(negedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_start", dm_start, 0);
        checkOutput("rst_grant", grant_id, 0);
        checkOutput("rst_moves_done", moves_done, 0);
        checkOutput("rst_src", dm_src_address, 0);
        applyReset();

        $display("[TB] single legal move on req0");
        mover_cycles = 100;
        applyStimulus(0, 64'h1000, 64'h8000, 64'h10000, 13'd4096);
        req_valid = 4'b0001;
        #1;
        checkOutput("t1_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_src", dm_src_address, 64'h1000);
        checkOutput("t1_dst", dm_dst_address, 64'h8000);
        checkOutput("t1_bytes", dm_byte_count, 64'h10000);
        checkOutput("t1_burst", dm_burst_size, 13'd4096);
        checkOutput("t1_nostart", dm_start, 0);
        @(negedge clk);
        checkOutput("t1_start", dm_start, 1);
        n = 0;
        while (done == '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t1_done", done, 4'b0001);
        checkOutput("t1_latency", n, 101);
        @(negedge clk);
        checkOutput("t1_moves_done", moves_done, 1);
        checkOutput("t1_idle", busy, 0);

        $display("[TB] round robin with all requesters valid");
        applyReset();
        mover_cycles = 3;
        for (int i = 0; i < NREQ; i++)
            applyStimulus(i, 64'h100 * (i + 1), 64'h9000, 64'h1000, 13'd64);
        req_valid = 4'b1111;
        serve(0, 1'b1, 4'b0000, "t2_g0");
        serve(1, 1'b1, 4'b0000, "t2_g1");
        serve(2, 1'b1, 4'b0000, "t2_g2");
        serve(3, 1'b1, 4'b0000, "t2_g3");
        serve(0, 1'b1, 4'b1111, "t2_g0b");
        @(negedge clk);
        checkOutput("t2_moves_done", moves_done, 5);

        $display("[TB] illegal descriptors on req2");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2, 64'h2000, 64'h9000, bad_bytes[i], bad_burst[i]);
            req_valid = 4'b0100;
            serve(2, 1'b0, 4'b0100, $sformatf("t3_bad%0d", i));
        end
        @(negedge clk);
        checkOutput("t3_moves_err", moves_err, 4);
        applyStimulus(2, 64'h2000, 64'h9000, bad_bytes[4], bad_burst[4]);
        req_valid = 4'b0100;
        serve(2, 1'b0, 4'b0100, "t3_overflow");
        applyStimulus(2, 64'h2000, 64'h9000, 64'h3F_FFFF_FFC0, 13'd64);
        req_valid = 4'b0100;
        serve(2, 1'b1, 4'b0100, "t3_maxbeats");
        @(negedge clk);
        checkOutput("t3_moves_err5", moves_err, 5);
        checkOutput("t3_moves_done", moves_done, 6);

        $display("[TB] enable dropped during wait");
        mover_cycles = 10;
        applyStimulus(0, 64'h3000, 64'hA000, 64'h2000, 13'd128);
        applyStimulus(1, 64'h4000, 64'hB000, 64'h2000, 13'd128);
        req_valid = 4'b0001;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("t4_ready0", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (dm_start == 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        sched_enable = 1'b0;
        req_valid    = 4'b0010;
        n = 0;
        while (done == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t4_done0", done, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("t4_held%0d", i), req_ready, 0);
        end
        sched_enable = 1'b1;
        #1;
        checkOutput("t4_regrant", req_ready, 4'b0010);
        serve(1, 1'b1, 4'b0010, "t4_g1");

        $display("[TB] reset during wait");
        mover_cycles = 20;
        applyStimulus(1, 64'h5000, 64'hC000, 64'h4000, 13'd256);
        req_valid = 4'b0010;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("t5_ready1", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (dm_start == 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_start", dm_start, 0);
        checkOutput("t5_done", done, 0);
        checkOutput("t5_moves_done", moves_done, 0);
        checkOutput("t5_src", dm_src_address, 0);
        checkOutput("t5_grant", grant_id, 0);
        dcount = 0;
        repeat (25) begin
            @(negedge clk);
            if (done != '0) dcount++;
        end
        checkOutput("t5_no_done", dcount, 0);
        resetn = 1'b1;
        for (int i = 0; i < NREQ; i++)
            applyStimulus(i, 64'h600 * (i + 1), 64'hD000, 64'h800, 13'd64);
        req_valid = 4'b1111;
        serve(0, 1'b1, 4'b1111, "t5_first");

        $display("[TB] moves_done wrap");
        @(negedge clk);
        force dut.moves_done = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.moves_done;
        #1;
        checkOutput("t6_preload", moves_done, 32'hFFFF_FFFF);
        applyStimulus(2, 64'h7000, 64'hE000, 64'h1000, 13'd512);
        req_valid = 4'b0100;
        serve(2, 1'b1, 4'b0100, "t6_move");
        @(negedge clk);
        checkOutput("t6_wrap", moves_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
